// File: rtl/axi_ram_slave_pkg.sv
// Shared AXI field widths, FSM state encodings and burst codes for axi_ram_slave.
// The `L* width macros are defined here so every file that follows sees them.
`ifndef AXI_RAM_SLAVE_DEFINES
`define AXI_RAM_SLAVE_DEFINES
`define Larid    4
`define Laraddr  32
`define Larlen   4
`define Larsize  3
`define Larburst 2
`define Larlock  2
`define Larcache 4
`define Larprot  3
`define Lrid     4
`define Lrdata   32
`define Lrresp   2
`define Lawid    4
`define Lawaddr  32
`define Lawlen   4
`define Lawsize  3
`define Lawburst 2
`define Lawlock  2
`define Lawcache 4
`define Lawprot  3
`define Lwid     4
`define Lwdata   32
`define Lwstrb   4
`define Lbid     4
`define Lbresp   2
`endif

package axi_ram_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

  // Any burst code other than FIXED advances by one 32-bit word.
  function automatic logic [`Laraddr-1:0] next_addr(input logic [`Laraddr-1:0] addr,
                                                   input logic [1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + `Laraddr'(4);
  endfunction

endpackage

// File: rtl/axi_ram_slave_mem.sv
// Word-organised RAM with per-byte write strobes and a registered read port.
// A read and write to the same word in one cycle returns the old contents.
module axi_ram_slave_mem
  import axi_ram_slave_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_BITS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Byte-enabled write; the array itself is never cleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data only changes when a new word is requested.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'd0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 RAM slave: one outstanding read burst and one outstanding write burst,
// each run by its own FSM over a shared byte-strobed memory.
module axi_ram_slave
  import axi_ram_slave_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [`Larid-1:0]     arid,
  input  logic [`Laraddr-1:0]   araddr,
  input  logic [`Larlen-1:0]    arlen,
  input  logic [`Larsize-1:0]   arsize,
  input  logic [`Larburst-1:0]  arburst,
  input  logic [`Larlock-1:0]   arlock,
  input  logic [`Larcache-1:0]  arcache,
  input  logic [`Larprot-1:0]   arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [`Lrid-1:0]      rid,
  output logic [`Lrdata-1:0]    rdata,
  output logic [`Lrresp-1:0]    rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [`Lawid-1:0]     awid,
  input  logic [`Lawaddr-1:0]   awaddr,
  input  logic [`Lawlen-1:0]    awlen,
  input  logic [`Lawsize-1:0]   awsize,
  input  logic [`Lawburst-1:0]  awburst,
  input  logic [`Lawlock-1:0]   awlock,
  input  logic [`Lawcache-1:0]  awcache,
  input  logic [`Lawprot-1:0]   awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [`Lwid-1:0]      wid,
  input  logic [`Lwdata-1:0]    wdata,
  input  logic [`Lwstrb-1:0]    wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [`Lbid-1:0]      bid,
  output logic [`Lbresp-1:0]    bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  r_state_e               r_state_q, r_state_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic                   rlast_q, rlast_d;
  logic [`Lrid-1:0]       rid_q, rid_d;
  logic [`Laraddr-1:0]    raddr_q, raddr_d;
  logic [`Larlen-1:0]     rlen_q, rlen_d;
  logic [`Larlen-1:0]     rcnt_q, rcnt_d;
  logic [`Larburst-1:0]   rburst_q, rburst_d;
  logic                   mem_re;
  logic [ADDR_BITS-1:0]   mem_raddr;

  w_state_e               w_state_q, w_state_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   bvalid_q, bvalid_d;
  logic [`Lbid-1:0]       bid_q, bid_d;
  logic [`Lawaddr-1:0]    waddr_q, waddr_d;
  logic [`Lawlen-1:0]     wlen_q, wlen_d;
  logic [`Lawlen-1:0]     wcnt_q, wcnt_d;
  logic [`Lawburst-1:0]   wburst_q, wburst_d;
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr;

  logic unused_inputs;
  assign unused_inputs = ^{arsize, arlock, arcache, arprot,
                           awsize, awlock, awcache, awprot, wid, wlast};

  // Read FSM: the next word is fetched on the AR handshake and on every non-final R handshake.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rburst_d  = rburst_q;
    mem_re    = 1'b0;
    mem_raddr = araddr[ADDR_BITS+1:2];
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          r_state_d = R_BURST;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (arlen == `Larlen'(0));
          rid_d     = arid;
          raddr_d   = araddr;
          rlen_d    = arlen;
          rburst_d  = arburst;
          rcnt_d    = `Larlen'(0);
          mem_re    = 1'b1;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_BURST: begin
        if (rready) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            rcnt_d    = rcnt_q + `Larlen'(1);
            raddr_d   = next_addr(raddr_q, rburst_q);
            rlast_d   = ((rcnt_q + `Larlen'(1)) == rlen_q);
            mem_re    = 1'b1;
            mem_raddr = raddr_d[ADDR_BITS+1:2];
          end
        end else begin
          r_state_d = R_BURST;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel registers; reset aborts any burst in flight.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= `Lrid'(0);
      raddr_q   <= `Laraddr'(0);
      rlen_q    <= `Larlen'(0);
      rcnt_q    <= `Larlen'(0);
      rburst_q  <= `Larburst'(0);
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rburst_q  <= rburst_d;
    end
  end

  // Write FSM: burst end comes from the beat count, never from wlast.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    wburst_d  = wburst_q;
    mem_we    = 1'b0;
    mem_waddr = waddr_q[ADDR_BITS+1:2];
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          w_state_d = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          bid_d     = awid;
          waddr_d   = awaddr;
          wlen_d    = awlen;
          wburst_d  = awburst;
          wcnt_d    = `Lawlen'(0);
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          mem_we = 1'b1;
          if (wcnt_q == wlen_q) begin
            w_state_d = W_RESP;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
          end else begin
            wcnt_d  = wcnt_q + `Lawlen'(1);
            waddr_d = next_addr(waddr_q, wburst_q);
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= `Lbid'(0);
      waddr_q   <= `Lawaddr'(0);
      wlen_q    <= `Lawlen'(0);
      wcnt_q    <= `Lawlen'(0);
      wburst_q  <= `Lawburst'(0);
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wburst_q  <= wburst_d;
    end
  end

  axi_ram_slave_mem #(
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk   (aclk),
    .rst   (areset),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (wdata),
    .wstrb (wstrb),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (rdata)
  );

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rresp   = RESP_OKAY;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = RESP_OKAY;

endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12: word-index width; memory depth is 2^ADDR_BITS 32-bit words.
REQ-002 SHALL have port aclk, input, 1: sole clock; all logic on the rising edge.
REQ-003 SHALL have port areset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have read-address inputs with the `L*` widths from defines.vh:
- arid: `Larid
- araddr: `Laraddr
- arlen: `Larlen
- arsize: `Larsize
- arburst: `Larburst
- arvalid: 1
REQ-005 SHALL have arlock, arcache and arprot as inputs (`L* widths), accepted and ignored.
REQ-006 SHALL have arready, output, 1: read address accepted.
REQ-007 SHALL have read-data outputs:
- rid: `Lrid
- rdata: `Lrdata
- rresp: `Lrresp
- rlast: 1
- rvalid: 1
REQ-008 SHALL have rready, input, 1.
REQ-009 SHALL have write-address inputs awid, awaddr, awlen, awsize, awburst, awvalid (`L* widths), plus awlock, awcache and awprot accepted and ignored; SHALL have awready, output, 1.
REQ-010 SHALL have write-data inputs wid, wdata, wstrb, wlast, wvalid (`L* widths); SHALL have wready, output, 1.
REQ-011 SHALL have write-response outputs bid (`Lbid), bresp (`Lbresp), bvalid (1); SHALL have bready, input, 1.

Function
REQ-012 Read and write paths SHALL be independent FSMs sharing one memory array; word index = addr[ADDR_BITS+1:2], wrapping modulo depth.
REQ-013 Read FSM states:
- R_IDLE: arready=1.
- AR handshake -> R_BURST; latch arid, araddr, arlen and arburst; register mem[index] into rdata.
REQ-014 First rvalid SHALL assert exactly 1 cycle after the AR handshake.
REQ-015 In R_BURST, rvalid=1 and arready=0; rdata, rid and rlast SHALL be held stable while rvalid && !rready.
REQ-016 On each R handshake:
- beat counter increments.
- address += 4 if arburst != FIXED(2'b00), else unchanged.
- next word registered, giving 1 beat/cycle under continuous rready.
REQ-017 rlast SHALL be 1 only on beat arlen; the R handshake with rlast -> R_IDLE, rvalid=0.
REQ-018 Write FSM states:
- W_IDLE: awready=1; AW handshake -> W_DATA, latching awid, awaddr, awlen, awburst.
- W_DATA: wready=1; each W handshake writes the bytes enabled by wstrb[i]; address updates as in REQ-016.
- Beat awlen -> W_RESP.
REQ-019 W_DATA burst end SHALL be decided by the beat count; wlast and wid SHALL be ignored.
REQ-020 W_RESP: bvalid=1, bid=latched awid, bresp=2'b00; B handshake -> W_IDLE.
REQ-021 rresp SHALL be 2'b00 (OKAY) always; arsize/awsize SHALL be ignored and every beat treated as 4 bytes.
REQ-022 Read and write of the same word in the same cycle: the read SHALL return pre-write data.
REQ-023 Zero-length burst (len=0): exactly one beat, rlast=1 on that beat.
REQ-024 No outstanding transactions beyond one read and one write; arready and awready SHALL stay 0 until the current burst completes.

Reset
REQ-025 On areset:
- FSMs go to R_IDLE and W_IDLE.
- Outputs: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rlast=0, rdata=0, rid=0, bid=0.
- Counters clear.
REQ-026 On the first cycle after areset deasserts, arready=1 and awready=1.
REQ-027 Reset mid-burst SHALL abort the burst with no further beats; memory contents SHALL be retained, not cleared.

Structure
REQ-028 FSM state encodings and the FIXED/INCR burst codes SHALL live in a shared package/defines file alongside defines.vh.
REQ-029 The memory array with byte-strobe write and registered read SHALL be one sub-module, axi_ram_slave_mem.

Verification
REQ-030 Single write then read:
- Stimulus: AW addr 0x10, len 0, id 3; wdata 0xDEADBEEF, wstrb 4'hF; then AR 0x10, id 5.
- Response: bid=3, bresp=0; rdata=0xDEADBEEF, rid=5, rlast=1, rvalid 1 cycle after AR.
REQ-031 INCR read burst:
- Stimulus: preload words 0x100..0x10C with 1,2,3,4; AR len 3, rready held high.
- Response: 4 consecutive beats 1,2,3,4; rlast only on the 4th.
REQ-032 Strobes:
- Stimulus: word at 0x20 = 0x11223344; write 0xAABBCCDD with wstrb 4'b0101.
- Response: readback 0x11BB33DD.
REQ-033 Backpressure:
- Stimulus: len 1 read with rready low for 3 cycles.
- Response: rdata, rlast and rid held stable; arready=0 throughout.
REQ-034 FIXED burst:
- Stimulus: write len 2 to 0x40 with data 7,8,9.
- Response: readback of 0x40 = 9; 0x44 unchanged.
REQ-035 Reset mid-burst:
- Stimulus: assert areset during beat 2 of a len 7 read.
- Response: next cycle rvalid=0; following cycle arready=1.
